// File: rtl/segm_frame_ctrl_if.sv
// Host configuration bus of the segmentation frame controller.
// The host writes shadow registers and requests a commit; the controller
// reports when it can accept traffic and when the active set changed.
interface segm_frame_ctrl_if;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic       cfg_commit;
  logic       cfg_ready;
  logic       cfg_applied;

  // Host side: drives writes and commits, observes status.
  modport master (
    output cfg_we, cfg_addr, cfg_wdata, cfg_commit,
    input  cfg_ready, cfg_applied
  );

  // Controller side: consumes writes and commits, reports status.
  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, cfg_commit,
    output cfg_ready, cfg_applied
  );
endinterface

// File: rtl/segm_frame_ctrl.sv
// Frame-synchronous control for the skin-colour segmentation path.
// Decodes vsync/de into pixel/line/frame position and holds the Cb/Cr
// window plus output-mux mode. Host writes land in shadow registers and
// are copied to the active set only right after a frame start, so a frame
// is always processed with a single consistent configuration.
module segm_frame_ctrl #(
  parameter logic       VS_POL   = 1'b1,
  parameter int         X_W      = 12,
  parameter int         Y_W      = 11,
  parameter logic [7:0] CB_MIN_D = 8'd77,
  parameter logic [7:0] CB_MAX_D = 8'd127,
  parameter logic [7:0] CR_MIN_D = 8'd133,
  parameter logic [7:0] CR_MAX_D = 8'd173
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vsync,
  input  logic              in_hsync,
  input  logic              in_de,
  segm_frame_ctrl_if.slave  cfg,
  output logic [7:0]        cb_min,
  output logic [7:0]        cb_max,
  output logic [7:0]        cr_min,
  output logic [7:0]        cr_max,
  output logic [1:0]        mode,
  output logic [X_W-1:0]    x_pos,
  output logic [Y_W-1:0]    y_pos,
  output logic              frame_start,
  output logic [15:0]       frame_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_APPLY   = 2'd2
  } state_t;

  localparam logic [X_W-1:0] X_MAX = {X_W{1'b1}};
  localparam logic [Y_W-1:0] Y_MAX = {Y_W{1'b1}};
  localparam logic [X_W-1:0] X_ONE = {{(X_W-1){1'b0}}, 1'b1};
  localparam logic [Y_W-1:0] Y_ONE = {{(Y_W-1){1'b0}}, 1'b1};

  state_t     state_r;
  state_t     state_next_s;
  logic       shadow_we_s;
  logic       apply_s;
  logic       vs_q_r;
  logic       de_q_r;
  logic       frame_start_s;
  logic [7:0] sh_cb_min_r;
  logic [7:0] sh_cb_max_r;
  logic [7:0] sh_cr_min_r;
  logic [7:0] sh_cr_max_r;
  logic [1:0] sh_mode_r;

  // hsync is only monitored upstream; keep it visibly consumed.
  logic unused_hsync_s;
  assign unused_hsync_s = in_hsync;

  // Frame start is the edge into the active vsync level.
  assign frame_start_s = (in_vsync == VS_POL) && (vs_q_r != VS_POL);

  // Sync edge-detector history; vsync history resets to the inactive level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_q_r <= ~VS_POL;
      de_q_r <= 1'b0;
    end else begin
      vs_q_r <= in_vsync;
      de_q_r <= in_de;
    end
  end

  // Position counters: frame start beats line end, counters saturate.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_pos       <= {X_W{1'b0}};
      y_pos       <= {Y_W{1'b0}};
      frame_cnt   <= 16'd0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_start_s;
      if (frame_start_s) begin
        x_pos     <= {X_W{1'b0}};
        y_pos     <= {Y_W{1'b0}};
        frame_cnt <= frame_cnt + 16'd1;
      end else if (in_de) begin
        if (!de_q_r) begin
          x_pos <= {X_W{1'b0}};
        end else if (x_pos != X_MAX) begin
          x_pos <= x_pos + X_ONE;
        end
      end else if (de_q_r) begin
        x_pos <= {X_W{1'b0}};
        if (y_pos != Y_MAX) begin
          y_pos <= y_pos + Y_ONE;
        end
      end
    end
  end

  // Commit FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Commit FSM next state: a commit waits for the next frame-start edge,
  // which excludes an edge seen in the commit cycle itself.
  always_comb begin
    state_next_s = state_r;
    shadow_we_s  = 1'b0;
    apply_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cfg.cfg_we) begin
          shadow_we_s = 1'b1;
        end else begin
          shadow_we_s = 1'b0;
        end
        if (cfg.cfg_commit) begin
          state_next_s = ST_PENDING;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_PENDING: begin
        if (frame_start_s) begin
          state_next_s = ST_APPLY;
        end else begin
          state_next_s = ST_PENDING;
        end
      end
      ST_APPLY: begin
        apply_s      = 1'b1;
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Shadow register file, writable only while idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_cb_min_r <= CB_MIN_D;
      sh_cb_max_r <= CB_MAX_D;
      sh_cr_min_r <= CR_MIN_D;
      sh_cr_max_r <= CR_MAX_D;
      sh_mode_r   <= 2'd0;
    end else if (shadow_we_s) begin
      case (cfg.cfg_addr)
        3'd0:    sh_cb_min_r <= cfg.cfg_wdata;
        3'd1:    sh_cb_max_r <= cfg.cfg_wdata;
        3'd2:    sh_cr_min_r <= cfg.cfg_wdata;
        3'd3:    sh_cr_max_r <= cfg.cfg_wdata;
        3'd4:    sh_mode_r   <= cfg.cfg_wdata[1:0];
        default: sh_mode_r   <= sh_mode_r;
      endcase
    end
  end

  // Active set follows the shadow set only in the apply cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cb_min <= CB_MIN_D;
      cb_max <= CB_MAX_D;
      cr_min <= CR_MIN_D;
      cr_max <= CR_MAX_D;
      mode   <= 2'd0;
    end else if (apply_s) begin
      cb_min <= sh_cb_min_r;
      cb_max <= sh_cb_max_r;
      cr_min <= sh_cr_min_r;
      cr_max <= sh_cr_max_r;
      mode   <= sh_mode_r;
    end
  end

  // Host status: ready tracks the idle state, applied pulses with the update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg.cfg_ready   <= 1'b1;
      cfg.cfg_applied <= 1'b0;
    end else begin
      cfg.cfg_ready   <= (state_next_s == ST_IDLE);
      cfg.cfg_applied <= apply_s;
    end
  end

endmodule

// File: tb/tb_segm_frame_ctrl.sv
// Bench for segm_frame_ctrl: directed scenarios plus randomized video and
// host traffic, every cycle compared with a behavioural model that counts
// de runs, line ends and frames and tracks a pending commit as plain flags.
module tb_segm_frame_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_vsync = 1'b0;
  logic        in_hsync = 1'b0;
  logic        in_de = 1'b0;
  logic [7:0]  cb_min, cb_max, cr_min, cr_max;
  logic [1:0]  mode;
  logic [11:0] x_pos;
  logic [10:0] y_pos;
  logic        frame_start;
  logic [15:0] frame_cnt;

  segm_frame_ctrl_if cfg_bus ();

  always #5 clk = ~clk;

  segm_frame_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_vsync(in_vsync), .in_hsync(in_hsync),
    .in_de(in_de), .cfg(cfg_bus),
    .cb_min(cb_min), .cb_max(cb_max), .cr_min(cr_min), .cr_max(cr_max),
    .mode(mode), .x_pos(x_pos), .y_pos(y_pos),
    .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [7:0] m_shadow [5];
  logic [7:0] m_active [5];
  bit m_pending, m_apply, m_prev_vs, m_prev_de, m_fs, m_applied;
  int m_run, m_lines, m_fcnt;

  task automatic model_defaults();
    m_shadow[0] = 8'd77;  m_shadow[1] = 8'd127;
    m_shadow[2] = 8'd133; m_shadow[3] = 8'd173; m_shadow[4] = 8'd0;
    for (int i = 0; i < 5; i++) m_active[i] = m_shadow[i];
    m_pending = 1'b0; m_apply = 1'b0; m_prev_vs = 1'b0; m_prev_de = 1'b0;
    m_fs = 1'b0; m_applied = 1'b0; m_run = 0; m_lines = 0; m_fcnt = 0;
  endtask

  // One clock edge of the specified behaviour, using inputs held at the edge.
  task automatic model_edge();
    bit fs;
    if (!rst_n) begin
      model_defaults();
    end else begin
      fs = in_vsync && !m_prev_vs;
      m_applied = 1'b0;
      if (m_apply) begin
        for (int i = 0; i < 5; i++) m_active[i] = m_shadow[i];
        m_applied = 1'b1;
        m_apply = 1'b0;
      end else if (m_pending) begin
        if (fs) begin
          m_pending = 1'b0;
          m_apply = 1'b1;
        end
      end else begin
        if (cfg_bus.cfg_we) begin
          if (cfg_bus.cfg_addr < 3'd4) m_shadow[cfg_bus.cfg_addr] = cfg_bus.cfg_wdata;
          else if (cfg_bus.cfg_addr == 3'd4) m_shadow[4] = {6'd0, cfg_bus.cfg_wdata[1:0]};
        end
        if (cfg_bus.cfg_commit) m_pending = 1'b1;
      end
      if (fs) begin
        m_fcnt = (m_fcnt + 1) % 65536;
        m_lines = 0;
        m_run = in_de ? 1 : 0;
      end else begin
        if (m_prev_de && !in_de) m_lines++;
        m_run = in_de ? ((m_run < 5000) ? m_run + 1 : 5000) : 0;
      end
      m_fs = fs;
      m_prev_vs = in_vsync;
      m_prev_de = in_de;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int ex, ey;
    ex = (m_run == 0) ? 0 : ((m_run - 1 > 4095) ? 4095 : m_run - 1);
    ey = (m_lines > 2047) ? 2047 : m_lines;
    chk("x_pos", {20'd0, x_pos}, ex);
    chk("y_pos", {21'd0, y_pos}, ey);
    chk("frame_start", {31'd0, frame_start}, {31'd0, m_fs});
    chk("frame_cnt", {16'd0, frame_cnt}, m_fcnt);
    chk("cfg_ready", {31'd0, cfg_bus.cfg_ready}, {31'd0, !(m_pending || m_apply)});
    chk("cfg_applied", {31'd0, cfg_bus.cfg_applied}, {31'd0, m_applied});
    chk("cb_min", {24'd0, cb_min}, {24'd0, m_active[0]});
    chk("cb_max", {24'd0, cb_max}, {24'd0, m_active[1]});
    chk("cr_min", {24'd0, cr_min}, {24'd0, m_active[2]});
    chk("cr_max", {24'd0, cr_max}, {24'd0, m_active[3]});
    chk("mode", {30'd0, mode}, {24'd0, m_active[4]});
  endtask

  // Drive one cycle of inputs, advance the model at the edge, check after it.
  task automatic tick(input bit vs, input bit de, input bit we,
                      input logic [2:0] addr, input logic [7:0] wd, input bit commit);
    in_vsync = vs;
    in_de = de;
    in_hsync = 1'($urandom);
    cfg_bus.cfg_we = we;
    cfg_bus.cfg_addr = addr;
    cfg_bus.cfg_wdata = wd;
    cfg_bus.cfg_commit = commit;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
  endtask

  task automatic video_line(input int len);
    for (int i = 0; i < len; i++) tick(1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
  endtask

  task automatic vsync_pulse();
    tick(1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
    idle(3);
  endtask

  task automatic rand_cycle(input bit vs, input bit de);
    bit we, cm;
    we = ($urandom_range(0, 7) == 0);
    cm = ($urandom_range(0, 15) == 0);
    tick(vs, de, we, 3'($urandom_range(0, 7)), 8'($urandom), cm);
  endtask

  initial begin
    cfg_bus.cfg_we = 1'b0; cfg_bus.cfg_addr = 3'd0;
    cfg_bus.cfg_wdata = 8'd0; cfg_bus.cfg_commit = 1'b0;
    model_defaults();

    // Reset held for three clocks
    rst_n = 1'b0;
    idle(3);
    chk("rst_cb_min", {24'd0, cb_min}, 32'd77);
    chk("rst_cb_max", {24'd0, cb_max}, 32'd127);
    chk("rst_cr_min", {24'd0, cr_min}, 32'd133);
    chk("rst_cr_max", {24'd0, cr_max}, 32'd173);
    chk("rst_mode", {30'd0, mode}, 32'd0);
    chk("rst_ready", {31'd0, cfg_bus.cfg_ready}, 32'd1);
    rst_n = 1'b1;
    idle(2);

    // Counters over three 640-pixel lines and a frame start
    vsync_pulse();
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < 640; i++) tick(1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0);
      chk("line_end_x", {20'd0, x_pos}, 32'd639);
      chk("line_y", {21'd0, y_pos}, l);
      tick(1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
      idle(2);
    end
    chk("y_after_3", {21'd0, y_pos}, 32'd3);
    vsync_pulse();
    chk("y_after_fs", {21'd0, y_pos}, 32'd0);
    chk("fcnt_2", {16'd0, frame_cnt}, 32'd2);

    // Deferred apply of cb_min=90 committed mid-frame
    video_line(20);
    tick(1'b0, 1'b0, 1'b1, 3'd0, 8'd90, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b1);
    chk("pend_ready", {31'd0, cfg_bus.cfg_ready}, 32'd0);
    // Blocked write while pending
    tick(1'b0, 1'b0, 1'b1, 3'd0, 8'd5, 1'b0);
    video_line(30);
    chk("pend_cb_min", {24'd0, cb_min}, 32'd77);
    tick(1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0);
    chk("fs_cb_min_old", {24'd0, cb_min}, 32'd77);
    tick(1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
    chk("apply_cb_min", {24'd0, cb_min}, 32'd90);
    chk("apply_pulse", {31'd0, cfg_bus.cfg_applied}, 32'd1);
    idle(3);
    chk("ready_back", {31'd0, cfg_bus.cfg_ready}, 32'd1);

    // Commit on the vsync-edge cycle applies one frame later
    tick(1'b0, 1'b0, 1'b1, 3'd4, 8'hFE, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
    idle(3);
    chk("same_cyc_mode", {30'd0, mode}, 32'd0);
    video_line(10);
    vsync_pulse();
    chk("next_frame_mode", {30'd0, mode}, 32'd2);

    // x and y saturation
    video_line(4100);
    for (int i = 0; i < 2050; i++) video_line(1);
    chk("y_sat", {21'd0, y_pos}, 32'd2047);
    vsync_pulse();

    // Randomized frames with sprinkled host traffic
    for (int f = 0; f < 8; f++) begin
      for (int c = 0; c < 3; c++) rand_cycle(1'b1, 1'b0);
      for (int c = 0; c < 3; c++) rand_cycle(1'b0, 1'b0);
      for (int l = 0; l < int'($urandom_range(2, 6)); l++) begin
        for (int p = 0; p < int'($urandom_range(1, 40)); p++) rand_cycle(1'b0, 1'b1);
        for (int g = 0; g < int'($urandom_range(1, 4)); g++) rand_cycle(1'b0, 1'b0);
      end
      // occasional frame start right on a de fall
      if ($urandom_range(0, 1) == 1) begin
        rand_cycle(1'b0, 1'b1);
        rand_cycle(1'b1, 1'b0);
      end
      rand_cycle(1'b0, 1'b0);
    end

    // Reset in the middle of a pending commit
    idle(4);
    tick(1'b0, 1'b0, 1'b1, 3'd1, 8'd200, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b1);
    idle(2);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(2);
    chk("rstp_ready", {31'd0, cfg_bus.cfg_ready}, 32'd1);
    vsync_pulse();
    chk("rstp_cb_max", {24'd0, cb_max}, 32'd127);
    chk("rstp_fcnt", {16'd0, frame_cnt}, 32'd1);
    chk("rstp_applied", {31'd0, cfg_bus.cfg_applied}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
